// File: rtl/puck_pkg.sv
// Shared constants, types and velocity helpers for the puck sequencer.
// Positions are 13-bit signed internally so off-screen moves stay visible.
package puck_pkg;

  localparam int SCREEN_W      = 1024;
  localparam int SCREEN_H      = 768;
  localparam int RADIUS        = 16;
  localparam int PADDLE_RADIUS = 24;
  localparam int GOAL_TOP      = 284;
  localparam int GOAL_BOTTOM   = 484;
  localparam int SERVE_SPEED   = 3;
  localparam int MIN_BOUNCE    = 2;
  localparam int VMAX          = 7;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int VW = 5;
  localparam int PW = 13;
  localparam int DW = 24;

  typedef logic signed [PW-1:0] pos_t;
  typedef logic signed [VW-1:0] vel_t;
  typedef logic [DW-1:0]        dist_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MOVE,
    S_WALL,
    S_HIT1,
    S_HIT2,
    S_COMMIT,
    S_GOAL
  } state_t;

  localparam pos_t X_MAX = pos_t'(SCREEN_W - 2*RADIUS);
  localparam pos_t Y_MAX = pos_t'(SCREEN_H - 2*RADIUS);
  localparam pos_t G_TOP = pos_t'(GOAL_TOP);
  localparam pos_t G_BOT = pos_t'(GOAL_BOTTOM);

  localparam logic [XW-1:0] X_SERVE = XW'(SCREEN_W/2 - RADIUS);
  localparam logic [YW-1:0] Y_SERVE = YW'(SCREEN_H/2 - RADIUS);

  function automatic vel_t vabs(input vel_t v);
    return v[VW-1] ? -v : v;
  endfunction

  function automatic vel_t vclamp(input vel_t v);
    if (v > vel_t'(VMAX))
      return vel_t'(VMAX);
    if (v < -vel_t'(VMAX))
      return -vel_t'(VMAX);
    return v;
  endfunction

  // Paddle bounce: keep speed but never below MIN_BOUNCE, point along neg.
  function automatic vel_t bounce(input vel_t v, input logic neg);
    vel_t m;
    m = vabs(v);
    if (m < vel_t'(MIN_BOUNCE))
      m = vel_t'(MIN_BOUNCE);
    if (m > vel_t'(VMAX))
      m = vel_t'(VMAX);
    return neg ? -m : m;
  endfunction

endpackage

// File: rtl/puck_if.sv
// Game-control / renderer side bundle of the puck sequencer.
// master = game logic and renderer, slave = puck_controller.
interface puck_if;
  import puck_pkg::*;

  logic          frame_start;
  logic          serve;
  logic          serve_dir;
  logic [XW-1:0] p1_x;
  logic [YW-1:0] p1_y;
  logic [XW-1:0] p2_x;
  logic [YW-1:0] p2_y;
  logic [XW-1:0] puck_x;
  logic [YW-1:0] puck_y;
  vel_t          vel_x;
  vel_t          vel_y;
  logic          display;
  logic          goal_left;
  logic          goal_right;
  logic          busy;

  modport master (
    output frame_start, serve, serve_dir,
    output p1_x, p1_y, p2_x, p2_y,
    input  puck_x, puck_y, vel_x, vel_y,
    input  display, goal_left, goal_right, busy
  );

  modport slave (
    input  frame_start, serve, serve_dir,
    input  p1_x, p1_y, p2_x, p2_y,
    output puck_x, puck_y, vel_x, vel_y,
    output display, goal_left, goal_right, busy
  );

endinterface

// File: rtl/puck_dist_check.sv
// Two-stage circle overlap test: stage 1 registers centre deltas,
// stage 2 squares, compares against the reach and reports the axis.
module puck_dist_check
  import puck_pkg::*;
#(
  parameter int REACH = RADIUS + PADDLE_RADIUS
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  pos_t ax,
  input  pos_t ay,
  input  pos_t bx,
  input  pos_t by,
  output logic hit,
  output logic neg_x,
  output logic neg_y,
  output logic x_major
);

  localparam dist_t REACH2 = dist_t'(REACH * REACH);

  pos_t          dx, dy;
  logic [PW-1:0] mx, my;
  dist_t         sq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (load) begin
      dx <= ax - bx;
      dy <= ay - by;
    end
  end

  always_comb begin
    mx      = dx[PW-1] ? -dx : dx;
    my      = dy[PW-1] ? -dy : dy;
    sq      = DW'(mx) * DW'(mx) + DW'(my) * DW'(my);
    hit     = sq <= REACH2;
    neg_x   = dx[PW-1];
    neg_y   = dy[PW-1];
    x_major = mx >= my;
  end

endmodule

// File: rtl/puck_controller.sv
// Per-frame puck motion sequencer: move, wall/goal, two paddle checks,
// then an atomic commit of position and velocity to the renderer.
module puck_controller
  import puck_pkg::*;
(
  input logic   clock,
  input logic   reset,
  puck_if.slave bus
);

  state_t        state, state_n;
  logic          phase, phase_n;
  pos_t          nx, ny, nx_n, ny_n;
  vel_t          vx, vy, vx_n, vy_n;
  logic [XW-1:0] px, px_n;
  logic [YW-1:0] py, py_n;
  vel_t          cvx, cvy, cvx_n, cvy_n;
  logic          gside, gside_n;

  pos_t tx, ty, ctr;
  vel_t tvx, tvy;
  logic in_goal;

  logic sel2, load;
  pos_t ax, ay, bx, by;
  logic hit, neg_x, neg_y, x_major;

  // The distance unit is shared: HIT1 feeds paddle 1, HIT2 paddle 2.
  assign sel2 = (state == S_HIT2);
  assign load = (state == S_HIT1 || state == S_HIT2) && !phase;
  assign ax   = nx + pos_t'(RADIUS);
  assign ay   = ny + pos_t'(RADIUS);
  assign bx   = pos_t'({2'b00, sel2 ? bus.p2_x : bus.p1_x})
              + pos_t'(PADDLE_RADIUS);
  assign by   = pos_t'({3'b000, sel2 ? bus.p2_y : bus.p1_y})
              + pos_t'(PADDLE_RADIUS);

  puck_dist_check u_dist (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .ax      (ax),
    .ay      (ay),
    .bx      (bx),
    .by      (by),
    .hit     (hit),
    .neg_x   (neg_x),
    .neg_y   (neg_y),
    .x_major (x_major)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 1'b0;
      nx    <= '0;
      ny    <= '0;
      vx    <= '0;
      vy    <= '0;
      px    <= X_SERVE;
      py    <= Y_SERVE;
      cvx   <= '0;
      cvy   <= '0;
      gside <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      nx    <= nx_n;
      ny    <= ny_n;
      vx    <= vx_n;
      vy    <= vy_n;
      px    <= px_n;
      py    <= py_n;
      cvx   <= cvx_n;
      cvy   <= cvy_n;
      gside <= gside_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    nx_n    = nx;
    ny_n    = ny;
    vx_n    = vx;
    vy_n    = vy;
    px_n    = px;
    py_n    = py;
    cvx_n   = cvx;
    cvy_n   = cvy;
    gside_n = gside;
    tx      = nx;
    ty      = ny;
    tvx     = vx;
    tvy     = vy;
    ctr     = '0;
    in_goal = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.serve) begin
          cvx_n   = bus.serve_dir ? vel_t'(SERVE_SPEED)
                                  : -vel_t'(SERVE_SPEED);
          cvy_n   = vel_t'(1);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.frame_start)
          state_n = S_MOVE;
      end
      S_MOVE: begin
        nx_n    = pos_t'({2'b00, px}) + pos_t'(cvx);
        ny_n    = pos_t'({3'b000, py}) + pos_t'(cvy);
        vx_n    = cvx;
        vy_n    = cvy;
        state_n = S_WALL;
      end
      S_WALL: begin
        if (ny[PW-1]) begin
          ty  = '0;
          tvy = vabs(vy);
        end else if (ny > Y_MAX) begin
          ty  = Y_MAX;
          tvy = -vabs(vy);
        end
        ctr     = ty + pos_t'(RADIUS);
        in_goal = (ctr >= G_TOP) && (ctr <= G_BOT);
        state_n = S_HIT1;
        phase_n = 1'b0;
        // A goal mouth overrides the side-wall reflection.
        if (nx[PW-1]) begin
          if (in_goal) begin
            state_n = S_GOAL;
            gside_n = 1'b1;
          end else begin
            tx  = '0;
            tvx = vabs(vx);
          end
        end else if (nx > X_MAX) begin
          if (in_goal) begin
            state_n = S_GOAL;
            gside_n = 1'b0;
          end else begin
            tx  = X_MAX;
            tvx = -vabs(vx);
          end
        end
        nx_n = tx;
        ny_n = ty;
        vx_n = tvx;
        vy_n = tvy;
      end
      S_HIT1, S_HIT2: begin
        phase_n = ~phase;
        if (phase) begin
          if (hit) begin
            if (x_major)
              vx_n = bounce(vx, neg_x);
            else
              vy_n = bounce(vy, neg_y);
          end
          state_n = (state == S_HIT1) ? S_HIT2 : S_COMMIT;
        end
      end
      S_COMMIT: begin
        px_n    = nx[XW-1:0];
        py_n    = ny[YW-1:0];
        cvx_n   = vclamp(vx);
        cvy_n   = vclamp(vy);
        state_n = S_WAIT;
      end
      S_GOAL: begin
        px_n    = X_SERVE;
        py_n    = Y_SERVE;
        cvx_n   = '0;
        cvy_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.puck_x     = px;
  assign bus.puck_y     = py;
  assign bus.vel_x      = cvx;
  assign bus.vel_y      = cvy;
  assign bus.display    = 1'b1;
  assign bus.goal_left  = (state == S_GOAL) && gside;
  assign bus.goal_right = (state == S_GOAL) && !gside;
  assign bus.busy       = (state == S_MOVE) || (state == S_WALL)
                       || (state == S_HIT1) || (state == S_HIT2)
                       || (state == S_COMMIT);

endmodule

// File: tb/tb_puck_controller.sv
// Scoreboard bench: a frame-level puck model predicts each update,
// the result is popped and compared when the DUT finishes the frame.
module tb_puck_controller;

  logic clock;
  logic reset;

  puck_if bus ();

  puck_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
    int goal;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  int m_x, m_y, m_vx, m_vy;
  bit m_idle;

  localparam int FAR_X = 2000;
  localparam int FAR_Y = 1000;

  task automatic expect_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int bnc(input int v, input int d);
    int m;
    m = (iabs(v) < 2) ? 2 : iabs(v);
    if (m > 7)
      m = 7;
    return (d >= 0) ? m : -m;
  endfunction

  task automatic model_reset();
    m_x    = 496;
    m_y    = 368;
    m_vx   = 0;
    m_vy   = 0;
    m_idle = 1'b1;
  endtask

  task automatic model_step(output exp_t e);
    int nx, ny, vx, vy, c, g, dx, dy;
    int qx[2];
    int qy[2];
    qx[0] = int'(bus.p1_x);
    qy[0] = int'(bus.p1_y);
    qx[1] = int'(bus.p2_x);
    qy[1] = int'(bus.p2_y);
    nx = m_x + m_vx;
    ny = m_y + m_vy;
    vx = m_vx;
    vy = m_vy;
    g  = 0;
    if (ny < 0) begin
      ny = 0;
      vy = iabs(vy);
    end else if (ny > 736) begin
      ny = 736;
      vy = -iabs(vy);
    end
    c = ny + 16;
    if (nx < 0) begin
      if (c >= 284 && c <= 484) g = 1;
      else begin nx = 0; vx = iabs(vx); end
    end else if (nx > 992) begin
      if (c >= 284 && c <= 484) g = 2;
      else begin nx = 992; vx = -iabs(vx); end
    end
    if (g == 0) begin
      for (int p = 0; p < 2; p++) begin
        dx = (nx + 16) - (qx[p] + 24);
        dy = (ny + 16) - (qy[p] + 24);
        if (dx*dx + dy*dy <= 1600) begin
          if (iabs(dx) >= iabs(dy)) vx = bnc(vx, dx);
          else vy = bnc(vy, dy);
        end
      end
      m_x  = nx;
      m_y  = ny;
      m_vx = vx;
      m_vy = vy;
    end else begin
      model_reset();
    end
    e = '{m_x, m_y, m_vx, m_vy, g};
  endtask

  task automatic set_pads(input int ax, input int ay,
                          input int bx, input int by);
    bus.p1_x = 11'(ax);
    bus.p1_y = 10'(ay);
    bus.p2_x = 11'(bx);
    bus.p2_y = 10'(by);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_reset();
    sb.delete();
  endtask

  task automatic do_serve(input bit dir);
    @(negedge clock);
    bus.serve     = 1'b1;
    bus.serve_dir = dir;
    @(negedge clock);
    bus.serve = 1'b0;
    if (m_idle) begin
      m_vx   = dir ? 3 : -3;
      m_vy   = 1;
      m_idle = 1'b0;
    end
    expect_eq("serve_vx", int'(bus.vel_x), m_vx);
    expect_eq("serve_vy", int'(bus.vel_y), m_vy);
  endtask

  task automatic do_frame(input bit extra, output int gseen);
    exp_t e;
    int   bc, pc, gc;
    bit   done, acc, late;
    acc = !m_idle;
    if (acc) begin
      model_step(e);
      sb.push_back(e);
    end
    @(negedge clock);
    bus.frame_start = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
    bc = 0; pc = 0; gc = 0; done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (extra && i == 2) bus.frame_start = 1'b1;
      if (extra && i == 3) bus.frame_start = 1'b0;
      if (bus.goal_left) begin pc++; gc = 1; end
      if (bus.goal_right) begin pc++; gc = 2; end
      if (bus.busy)
        bc++;
      else if (!bus.goal_left && !bus.goal_right) begin
        if (acc && bc > 0) begin done = 1'b1; break; end
        if (!acc && i >= 11) begin done = 1'b1; break; end
      end
      @(negedge clock);
    end
    gseen = gc;
    if (!done) begin
      expect_eq("timeout", 0, 1);
    end else if (!acc) begin
      expect_eq("idle_busy", bc, 0);
      expect_eq("idle_x", int'(bus.puck_x), m_x);
      expect_eq("idle_y", int'(bus.puck_y), m_y);
    end else if (sb.size() == 0) begin
      expect_eq("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      expect_eq("x", int'(bus.puck_x), e.x);
      expect_eq("y", int'(bus.puck_y), e.y);
      expect_eq("vx", int'(bus.vel_x), e.vx);
      expect_eq("vy", int'(bus.vel_y), e.vy);
      expect_eq("goal", gc, e.goal);
      expect_eq("pulses", pc, (e.goal != 0) ? 1 : 0);
      expect_eq("busy_len", bc, (e.goal != 0) ? 2 : 7);
    end
    if (extra) begin
      late = 1'b0;
      repeat (4) begin
        @(negedge clock);
        if (bus.busy) late = 1'b1;
      end
      expect_eq("drop_extra", int'(late), 0);
    end
  endtask

  int g;
  int cx, cy;

  initial begin
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.serve       = 1'b0;
    bus.serve_dir   = 1'b0;
    set_pads(FAR_X, FAR_Y, FAR_X, FAR_Y);
    model_reset();
    #1;
    expect_eq("rst_x", int'(bus.puck_x), 496);
    expect_eq("rst_y", int'(bus.puck_y), 368);
    expect_eq("rst_vx", int'(bus.vel_x), 0);
    expect_eq("rst_vy", int'(bus.vel_y), 0);
    expect_eq("rst_disp", int'(bus.display), 1);
    expect_eq("rst_gl", int'(bus.goal_left), 0);
    expect_eq("rst_gr", int'(bus.goal_right), 0);
    expect_eq("rst_busy", int'(bus.busy), 0);
    do_reset();

    do_frame(1'b0, g);

    do_serve(1'b1);
    do_frame(1'b0, g);
    expect_eq("f1_x", int'(bus.puck_x), 499);
    expect_eq("f1_y", int'(bus.puck_y), 369);

    do_serve(1'b0);
    do_frame(1'b1, g);

    cx = m_x + m_vx + 16;
    cy = m_y + m_vy + 16;
    set_pads(FAR_X, FAR_Y, cx + 30 - 24, cy - 24);
    do_frame(1'b0, g);
    expect_eq("pad_vx", int'(bus.vel_x), -3);
    set_pads(FAR_X, FAR_Y, FAR_X, FAR_Y);

    cx = m_x + m_vx + 16;
    cy = m_y + m_vy + 16;
    set_pads(cx - 24, cy + 30 - 24, FAR_X, FAR_Y);
    do_frame(1'b0, g);
    expect_eq("pad_vy", int'(bus.vel_y), -2);
    set_pads(FAR_X, FAR_Y, FAR_X, FAR_Y);

    for (int k = 0; k < 300; k++)
      do_frame(1'b0, g);

    @(negedge clock);
    bus.frame_start = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    expect_eq("mid_rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clock);
    expect_eq("mid_rst_x", int'(bus.puck_x), 496);
    expect_eq("mid_rst_y", int'(bus.puck_y), 368);
    expect_eq("mid_rst_vx", int'(bus.vel_x), 0);
    model_reset();
    sb.delete();

    do_serve(1'b0);
    for (int k = 0; k < 98; k++)
      do_frame(1'b0, g);
    cx = m_x + m_vx + 16;
    cy = m_y + m_vy + 16;
    set_pads(cx - 24, cy + 30 - 24, FAR_X, FAR_Y);
    do_frame(1'b0, g);
    expect_eq("steer_vy", int'(bus.vel_y), -2);
    set_pads(FAR_X, FAR_Y, FAR_X, FAR_Y);

    g = 0;
    for (int k = 0; k < 150 && g == 0; k++)
      do_frame(1'b0, g);
    expect_eq("goal_left", g, 1);
    expect_eq("goal_vx", int'(bus.vel_x), 0);

    do_frame(1'b0, g);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
